codec_serial_responder: RTL and testbench



---
 rtl/codec_serial_responder_pkg.sv | 19 +
 rtl/codec_serial_responder_if.sv | 28 ++
 rtl/codec_serial_responder_sync_edge_det.sv | 32 +++
 rtl/codec_serial_responder.sv | 146 ++++++++++++++
 tb/tb_codec_serial_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/codec_serial_responder_pkg.sv
// codec_pkg: shared constants and types for the codec serial-port responder.
//   DATA_W  - sample width in bits
//   SLOT_W  - SCLK periods per LRCLK half-frame
//   MSB_POS - bit-count position carrying the sample MSB (I2S one-bit delay)
//   LSB_POS - bit-count position carrying the sample LSB
//   state_t - responder state: SYNC until the first LRCLK edge, then SLOT
package codec_pkg;

   localparam int unsigned DATA_W  = 24;
   localparam int unsigned SLOT_W  = 32;
   localparam int unsigned MSB_POS = 1;
   localparam int unsigned LSB_POS = MSB_POS + DATA_W - 1;

   typedef enum logic {
      SYNC,
      SLOT
   } state_t;

endpackage

// File: rtl/codec_serial_responder_if.sv
// codec_serial_responder_if: the four-wire I2S link between the codec
// interface (master) and the codec or its stand-in (slave).
//   LRCLK - frame clock, low = left slot, high = right slot (master drives)
//   SCLK  - bit clock (master drives)
//   SDin  - serial DAC data toward the codec (master drives)
//   SDout - serial ADC data toward the master (slave drives)
interface codec_serial_responder_if;

   logic LRCLK;
   logic SCLK;
   logic SDin;
   logic SDout;

   modport master (
      output LRCLK,
      output SCLK,
      output SDin,
      input  SDout
   );

   modport slave (
      input  LRCLK,
      input  SCLK,
      input  SDin,
      output SDout
   );

endinterface

// File: rtl/codec_serial_responder_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer for a master-generated clock line,
// followed by a third stage used to produce registered one-clk edge pulses.
//   clk  - system clock
//   rst  - synchronous active-high reset (clears the pulse outputs)
//   d    - asynchronous-domain input line
//   rise - one-clk pulse, 3 clk after d rises
//   fall - one-clk pulse, 3 clk after d falls
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [2:0] sr;

   // The shift stages free-run through reset so they already hold the real
   // line level at release; resetting them to 0 would fake an edge whenever
   // the line idles high.
   always_ff @(posedge clk) begin
      sr <= {sr[1:0], d};
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= sr[1] & ~sr[2];
         fall <= ~sr[1] & sr[2];
      end
   end

endmodule

// File: rtl/codec_serial_responder.sv
// codec_serial_responder: slave end of the codec I2S link. Follows the
// master's LRCLK/SCLK, shifts tx_lft/tx_rht out on SDout (MSB first, one-bit
// delay) and captures SDin words into rx_lft/rx_rht.
//   clk, rst        - system clock, synchronous active-high reset
//   bus (slave)     - LRCLK, SCLK, SDin in; SDout out
//   tx_lft, tx_rht  - samples to transmit, latched on each LRCLK edge
//   rx_lft, rx_rht  - last captured left/right samples
//   rx_vld          - one-clk pulse, 1 clk after a left/right pair completes
//   frm_err         - sticky: LRCLK edge at a bad slot position
module codec_serial_responder #(
   parameter int unsigned DATA_W = codec_pkg::DATA_W,
   parameter int unsigned SLOT_W = codec_pkg::SLOT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   codec_serial_responder_if.slave bus,
   input  logic [DATA_W-1:0]     tx_lft,
   input  logic [DATA_W-1:0]     tx_rht,
   output logic [DATA_W-1:0]     rx_lft,
   output logic [DATA_W-1:0]     rx_rht,
   output logic                  rx_vld,
   output logic                  frm_err
);

   import codec_pkg::*;

   localparam int unsigned CNT_W = $clog2(SLOT_W);
   localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(MSB_POS);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(MSB_POS + DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_W - 1);

   logic lr_rise, lr_fall, lr_edge;
   logic sclk_rise, sclk_fall;
   logic [1:0] sdin_sr;
   logic sdin_s;

   state_t            state;
   logic [CNT_W-1:0]  bcnt;
   logic [CNT_W-1:0]  bcnt_nx;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-2:0] rx_sh;
   logic [DATA_W-1:0] rx_word;
   logic              slot_rht;
   logic              have_lft;
   logic              vld_pend;

   sync_edge_det u_lr_det (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.LRCLK),
      .rise (lr_rise),
      .fall (lr_fall)
   );

   sync_edge_det u_sclk_det (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   always_ff @(posedge clk) begin
      sdin_sr <= {sdin_sr[0], bus.SDin};
   end

   assign sdin_s  = sdin_sr[1];
   assign lr_edge = lr_rise | lr_fall;
   assign bcnt_nx = bcnt + CNT_W'(1);
   assign rx_word = {rx_sh, sdin_s};

   function automatic logic in_data(input logic [CNT_W-1:0] c);
      return (c >= FIRST_CNT) && (c <= LAST_BIT);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SYNC;
         bcnt      <= '0;
         tx_sh     <= '0;
         rx_sh     <= '0;
         slot_rht  <= 1'b0;
         have_lft  <= 1'b0;
         vld_pend  <= 1'b0;
         bus.SDout <= 1'b0;
         rx_lft    <= '0;
         rx_rht    <= '0;
         rx_vld    <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         rx_vld   <= vld_pend;
         vld_pend <= 1'b0;
         case (state)
            SYNC: begin
               bus.SDout <= 1'b0;
               if (lr_edge) begin
                  state    <= SLOT;
                  bcnt     <= '0;
                  slot_rht <= lr_rise;
                  tx_sh    <= lr_rise ? tx_rht : tx_lft;
                  have_lft <= 1'b0;
               end
            end
            SLOT: begin
               // Receive first so a coincident LRCLK edge below overrides
               // the pairing flag.
               if (sclk_rise && in_data(bcnt)) begin
                  rx_sh <= rx_word[DATA_W-2:0];
                  if (bcnt == LAST_BIT) begin
                     if (slot_rht) begin
                        rx_rht   <= rx_word;
                        vld_pend <= have_lft;
                        have_lft <= 1'b0;
                     end else begin
                        rx_lft   <= rx_word;
                        have_lft <= 1'b1;
                     end
                  end
               end
               // LRCLK moves on an SCLK fall, so the edge takes precedence
               // and that fall becomes count 0.
               if (lr_edge) begin
                  bcnt      <= '0;
                  slot_rht  <= lr_rise;
                  tx_sh     <= lr_rise ? tx_rht : tx_lft;
                  bus.SDout <= 1'b0;
                  have_lft  <= lr_rise & have_lft & (bcnt == LAST_CNT);
                  if (bcnt != LAST_CNT) begin
                     frm_err <= 1'b1;
                  end
               end else if (sclk_fall) begin
                  bcnt <= bcnt_nx;
                  if (in_data(bcnt_nx)) begin
                     bus.SDout <= tx_sh[DATA_W-1];
                     tx_sh     <= {tx_sh[DATA_W-2:0], 1'b0};
                  end else begin
                     bus.SDout <= 1'b0;
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_codec_serial_responder.sv
// tb_codec_serial_responder: drives the link as an I2S master (SCLK = clk/16,
// LRCLK = clk/1024), recovers SDout words on SCLK rises, and scoreboards
// captured left/right pairs against what the master sent.
module tb_codec_serial_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] tx_lft, tx_rht;
   logic [23:0] rx_lft, rx_rht;
   logic        rx_vld, frm_err;
   logic        m_sdin = 1'b0;
   logic        loop_en = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic [47:0] rxq[$];

   always #5 clk = ~clk;

   codec_serial_responder_if bus ();

   assign bus.SDin = loop_en ? bus.SDout : m_sdin;

   codec_serial_responder #(
      .DATA_W (24),
      .SLOT_W (32)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .tx_lft  (tx_lft),
      .tx_rht  (tx_rht),
      .rx_lft  (rx_lft),
      .rx_rht  (rx_rht),
      .rx_vld  (rx_vld),
      .frm_err (frm_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_idle(input string nm);
      chk(nm, 32'({bus.SDout, rx_vld, frm_err, rx_lft != 24'd0, rx_rht != 24'd0}), 32'd0);
   endtask

   // One LRCLK half-frame of nfalls SCLK periods. The word the responder
   // should send is whatever tx was when the half-frame began.
   task automatic half(input logic side, input logic [23:0] din, input int nfalls,
                       input logic chk_tx, input logic do_chg, input logic [23:0] chg_val);
      logic [23:0] exp_tx, got;
      logic        tail_bad;
      logic [4:0]  bi;
      exp_tx   = side ? tx_rht : tx_lft;
      got      = '0;
      tail_bad = 1'b0;
      for (int k = 0; k < nfalls; k++) begin
         bi = 5'(24 - k);
         bus.SCLK = 1'b0;
         if (k == 0) bus.LRCLK = side;
         m_sdin = (k >= 1 && k <= 24) ? din[bi] : 1'b0;
         if (do_chg && k == 10) tx_lft = chg_val;
         tick(8);
         bus.SCLK = 1'b1;
         if (k >= 1 && k <= 24) got[bi] = bus.SDout;
         else if (bus.SDout !== 1'b0) tail_bad = 1'b1;
         tick(8);
      end
      if (chk_tx) begin
         chk(side ? "tx_rht_word" : "tx_lft_word", 32'(got), 32'(exp_tx));
         chk("tx_pad_zero", 32'(tail_bad), 32'd0);
      end
   endtask

   task automatic frame(input logic [23:0] l, input logic [23:0] r);
      rxq.push_back({l, r});
      half(1'b0, l, 32, 1'b1, 1'b0, 24'd0);
      half(1'b1, r, 32, 1'b1, 1'b0, 24'd0);
   endtask

   // Scoreboard monitor: every rx_vld pulse consumes one expected pair.
   initial begin
      logic        prev_vld;
      logic [23:0] d1, d2, d3, er;
      logic [47:0] e;
      prev_vld = 1'b0;
      d1 = '0; d2 = '0; d3 = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_vld = 1'b0;
         end else begin
            if (rx_vld) begin
               chk("vld_width", 32'(prev_vld), 32'd0);
               if (rxq.size() == 0) begin
                  chk("vld_unexpected", 32'd1, 32'd0);
               end else begin
                  e  = rxq.pop_front();
                  er = e[23:0];
                  chk("rx_lft", 32'(rx_lft), 32'(e[47:24]));
                  chk("rx_rht", 32'(rx_rht), 32'(er));
                  chk("rht_pre_vld", 32'(d1), 32'(er));
                  if (d3 != er) chk("vld_lag", 32'(d2 != er), 32'd1);
               end
            end
            prev_vld = rx_vld;
         end
         d3 = d2;
         d2 = d1;
         d1 = rx_rht;
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [23:0] l, r;
      int          waited;
      rst = 1'b1;
      bus.LRCLK = 1'b0;
      bus.SCLK  = 1'b0;
      tx_lft = '0;
      tx_rht = '0;

      // Reset with random clock lines, then park them high before release.
      repeat (3) begin
         @(negedge clk);
         bus.LRCLK = 1'($urandom());
         bus.SCLK  = 1'($urandom());
         chk_idle("reset_outputs");
      end
      @(negedge clk);
      bus.LRCLK = 1'b1;
      bus.SCLK  = 1'b1;
      repeat (5) begin
         tick(1);
         chk_idle("reset_outputs");
      end
      rst = 1'b0;
      repeat (20) begin
         tick(1);
         chk_idle("sync_quiet");
      end

      // Directed transmit/receive patterns.
      tx_lft = 24'hA5_0F3C;
      tx_rht = 24'h80_0001;
      frame(24'h12_3456, 24'hFE_DCBA);
      frame(24'h12_3456, 24'hFE_DCBA);

      // Random words in both directions.
      repeat (4) begin
         tx_lft = 24'($urandom());
         tx_rht = 24'($urandom());
         l = 24'($urandom());
         r = 24'($urandom());
         frame(l, r);
      end

      // tx_lft changes mid-slot: current word keeps the old value.
      tx_lft = 24'h11_1111;
      rxq.push_back({24'h0F_00F0, 24'h55_AA55});
      half(1'b0, 24'h0F_00F0, 32, 1'b1, 1'b1, 24'h22_2222);
      half(1'b1, 24'h55_AA55, 32, 1'b1, 1'b0, 24'd0);
      chk("tx_new_value_next", 32'(tx_lft), 32'h22_2222);
      frame(24'h33_3333, 24'h44_4444);

      // Loopback: SDout feeds SDin.
      loop_en = 1'b1;
      tx_lft = 24'h7F_FFFF;
      tx_rht = 24'h00_0000;
      repeat (3) frame(24'h7F_FFFF, 24'h00_0000);
      loop_en = 1'b0;

      // Framing error: LRCLK edge arrives at bit count 12 of a left slot.
      chk("frm_err_clear", 32'(frm_err), 32'd0);
      tx_lft = 24'h13_579B;
      tx_rht = 24'h24_68AC;
      half(1'b0, 24'h0A_BCDE, 13, 1'b0, 1'b0, 24'd0);
      half(1'b1, 24'h61_7283, 32, 1'b1, 1'b0, 24'd0);
      chk("frm_err_set", 32'(frm_err), 32'd1);
      chk("partial_not_written", 32'(rx_lft), 32'h7F_FFFF);
      frame(24'h9A_BCDE, 24'h01_2345);
      frame(24'($urandom()), 24'($urandom()));
      chk("frm_err_sticky", 32'(frm_err), 32'd1);

      waited = 0;
      while (rxq.size() != 0 && waited < 200) begin
         tick(1);
         waited++;
      end
      chk("rx_drain", 32'(rxq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
